ctr_pr_tc: RTL and testbench
============================

Name: ctr_pr_tc

Overview:
Parametrised pseudo-random counter built from an n-bit shift register. The shift register uses a 4-input LUT-driven feedback bit and can run as a nonlinear or linear FSR. It extends the basic ctr_pr with selectable taps, a runtime seed load, terminal-count detection, auto-reload and a zero-state guard. It is used as a cheap frequency divider or sequence generator wherever a binary counter's carry chain is unwanted.

Parameters:
n, 5, state/output width; legal range 5..24.
lut_data, 16'h6996, feedback LUT contents; the feedback bit is lut_data[idx]. The default is 4-input parity, i.e. an LFSR.
t3, 4, state bit index driving LUT input bit 3.
t2, 3, state bit index driving LUT input bit 2.
t1, 1, state bit index driving LUT input bit 1.
t0, 0, state bit index driving LUT input bit 0.
SEED, 1, state loaded on reset; n bits wide.
ZG, 1, zero-state guard enable: 1 = the all-zero state always shifts in 1.

Ports:
clk  input  1  clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
inc  input  1  advance enable; one step per clk edge while high.
ld  input  1  load seed into state; takes priority over inc.
seed  input  n  runtime load value.
tc_val  input  n  terminal state to detect.
reload_en  input  1  1 = on terminal state, reload seed instead of stepping.
out  output  n  current state, registered.
tc  output  1  registered terminal-count pulse.

Behaviour:
- Reset (rst=1 at a clk edge): out <= SEED, tc <= 0. Reset beats ld and inc, including mid-sequence.
- LUT index: idx = {out[t3], out[t2], out[t1], out[t0]}.
- Feedback: fb = lut_data[idx]. If ZG=1 and out == 0, fb = 1 regardless of the LUT.
- Step: out <= {out[n-2:0], fb}. This is a left shift, with the new bit entering at LSB.
- Priority per edge: rst > ld > inc > hold.
- ld=1: out <= seed, tc <= 0; inc is ignored on that edge.
- inc=1, ld=0, out != tc_val: step; tc <= 0.
- inc=1, ld=0, out == tc_val:
  - tc <= 1 for exactly one cycle.
  - reload_en=1: out <= seed.
  - reload_en=0: step normally.
- inc=0 (no ld/rst): out holds and tc <= 0. A tc pulse never stretches across hold cycles.
- Divider period: with reload_en=1 and inc held high, the period equals the number of steps from seed to tc_val, plus 1. If tc_val is never reached, tc never asserts; no error flag is raised.
- Latency: out and tc both change on the edge where the condition is sampled. Neither output has a combinational path from any input.
- seed, tc_val and reload_en are sampled only at clock edges. They may change every cycle.
- The generic implementation must elaborate for every legal n and tap set.
- Parameter check at elaboration: t0..t3 must all be < n. Violation is a fatal error.

Test Plan:
- Reset/step: rst for 1 cycle, then inc=1 for 3 cycles (defaults) -> out = 00001, 00011, 00110, 01101.
- Zero guard: ld seed=00000, then inc for 1 cycle -> ZG=1: out=00001; rebuild with ZG=0: out stays 00000.
- Terminal/reload: seed=00001, tc_val=00110, reload_en=1, inc held high -> out cycles 00001, 00011, 00110, 00001, … with period 3. tc is 1 exactly on the cycle out returns to 00001.
- Terminal without reload: same as the previous scenario with reload_en=0 -> after 00110, out=01101 and tc=1 for one cycle.
- Priority: at out=00011, drive ld=1, inc=1, seed=10101 -> out=10101, tc=0. Then assert rst together with ld -> out=00001.
- Hold, then reset mid-sequence: inc=0 for 5 cycles -> out constant, tc=0. Then rst during a reload-mode run -> out=SEED and tc=0 on the next edge.

Source files
------------

// File: rtl/ctr_pr_tc.sv
// Pseudo-random counter: n-bit shift register with 4-input LUT feedback,
// runtime seed load, terminal-count pulse, optional auto-reload and zero-state guard.
module ctr_pr_tc #(
  parameter int          n        = 5,
  parameter logic [15:0] lut_data = 16'h6996,
  parameter int          t3       = 4,
  parameter int          t2       = 3,
  parameter int          t1       = 1,
  parameter int          t0       = 0,
  parameter logic [n-1:0] SEED    = {{(n-1){1'b0}}, 1'b1},
  parameter bit          ZG       = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         ld,
  input  logic [n-1:0] seed,
  input  logic [n-1:0] tc_val,
  input  logic         reload_en,
  output logic [n-1:0] out,
  output logic         tc
);

  if (n < 5 || n > 24 || t0 >= n || t1 >= n || t2 >= n || t3 >= n ||
      t0 < 0 || t1 < 0 || t2 < 0 || t3 < 0) begin : g_param_check
    $fatal(1, "ctr_pr_tc: n must be 5..24 and taps t0..t3 must be in 0..n-1");
  end

  logic [n-1:0] out_q, out_d;
  logic         tc_q, tc_d;
  logic [3:0]   idx;
  logic         fb;
  logic [n-1:0] step;

  assign idx  = {out_q[t3], out_q[t2], out_q[t1], out_q[t0]};
  // An all-zero register would lock up an LFSR; the guard forces a 1 in.
  assign fb   = (ZG && (out_q == '0)) ? 1'b1 : lut_data[idx];
  assign step = {out_q[n-2:0], fb};

  always_comb begin
    out_d = out_q;
    tc_d  = 1'b0;
    if (ld) begin
      out_d = seed;
    end else if (inc) begin
      if (out_q == tc_val) begin
        tc_d  = 1'b1;
        out_d = reload_en ? seed : step;
      end else begin
        out_d = step;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= SEED;
      tc_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      tc_q  <= tc_d;
    end
  end

  assign out = out_q;
  assign tc  = tc_q;

endmodule

// File: tb/tb_ctr_pr_tc.sv
// Directed bench for ctr_pr_tc: default LFSR instance plus a ZG=0 twin sharing inputs.
module tb_ctr_pr_tc;
  logic       clk = 1'b0;
  logic       rst, inc, ld, reload_en;
  logic [4:0] seed, tc_val;
  logic [4:0] out, out2;
  logic       tc, tc2;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  ctr_pr_tc dut (
    .clk(clk), .rst(rst), .inc(inc), .ld(ld), .seed(seed), .tc_val(tc_val),
    .reload_en(reload_en), .out(out), .tc(tc)
  );

  ctr_pr_tc #(.ZG(1'b0)) dut_nozg (
    .clk(clk), .rst(rst), .inc(inc), .ld(ld), .seed(seed), .tc_val(tc_val),
    .reload_en(reload_en), .out(out2), .tc(tc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] rl_out [6] = '{5'b00011, 5'b00110, 5'b00001, 5'b00011, 5'b00110, 5'b00001};
  logic       rl_tc  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [4:0] nr_out [4] = '{5'b00011, 5'b00110, 5'b01101, 5'b11010};
  logic       nr_tc  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; inc = 1'b0; ld = 1'b0; reload_en = 1'b0;
    seed = 5'b00000; tc_val = 5'b11111;
    tick();
    chk("reset_out", out, 5'b00001);
    chk("reset_tc", tc, 1'b0);
    chk("reset_out_nozg", out2, 5'b00001);

    rst = 1'b0; inc = 1'b1;
    tick(); chk("step1", out, 5'b00011);
    tick(); chk("step2", out, 5'b00110);
    tick(); chk("step3", out, 5'b01101);
    chk("step3_tc", tc, 1'b0);

    // Zero-state guard
    inc = 1'b0; ld = 1'b1; seed = 5'b00000;
    tick(); chk("ld_zero", out, 5'b00000); chk("ld_zero_nozg", out2, 5'b00000);
    ld = 1'b0; inc = 1'b1;
    tick(); chk("zg_on", out, 5'b00001); chk("zg_off", out2, 5'b00000);

    // Terminal count with reload
    inc = 1'b0; ld = 1'b1; seed = 5'b00001;
    tick(); chk("ld_seed", out, 5'b00001); chk("ld_seed_tc", tc, 1'b0);
    ld = 1'b0; inc = 1'b1; tc_val = 5'b00110; reload_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("reload_out%0d", i), out, rl_out[i]);
      chk($sformatf("reload_tc%0d", i), tc, rl_tc[i]);
    end

    // Terminal count without reload
    reload_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("noreload_out%0d", i), out, nr_out[i]);
      chk($sformatf("noreload_tc%0d", i), tc, nr_tc[i]);
    end

    // Priority: ld over inc, rst over ld
    inc = 1'b0; ld = 1'b1; seed = 5'b00001;
    tick();
    ld = 1'b0; inc = 1'b1;
    tick(); chk("prio_pre", out, 5'b00011);
    ld = 1'b1; seed = 5'b10101;
    tick(); chk("prio_ld_out", out, 5'b10101); chk("prio_ld_tc", tc, 1'b0);
    rst = 1'b1;
    tick(); chk("prio_rst_out", out, 5'b00001); chk("prio_rst_tc", tc, 1'b0);

    // tc pulse followed by hold cycles
    rst = 1'b0; ld = 1'b0; inc = 1'b1; reload_en = 1'b1; seed = 5'b00001;
    tick(); chk("hold_pre1", out, 5'b00011);
    tick(); chk("hold_pre2", out, 5'b00110);
    tick(); chk("hold_pre3", out, 5'b00001); chk("hold_pre3_tc", tc, 1'b1);
    inc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("hold_out%0d", i), out, 5'b00001);
      chk($sformatf("hold_tc%0d", i), tc, 1'b0);
    end

    // Reset mid reload run, on the edge that would otherwise fire tc
    inc = 1'b1; seed = 5'b10101;
    tick(); chk("run1", out, 5'b00011);
    tick(); chk("run2", out, 5'b00110);
    rst = 1'b1;
    tick(); chk("midrst_out", out, 5'b00001); chk("midrst_tc", tc, 1'b0);
    rst = 1'b0; inc = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
